periph_bus_arbiter: RTL and testbench

PERIPH_BUS_ARBITER -- requirements
Module: periph_bus_arbiter

---
 rtl/periph_bus_pkg.sv | 42 ++++
 rtl/arb_grant_select.sv | 40 ++++
 rtl/periph_bus_arbiter.sv | 170 +++++++++++++++++
 tb/tb_periph_bus_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/periph_bus_pkg.sv
// Shared types and constants for the two-requester peripheral bus arbiter.
// Holds the arbiter state encoding, bus geometry, read-latency bounds and
// the latched-transfer record used between arbitration and bus access.
package periph_bus_pkg;

   // Peripheral bus geometry: word address bits [23:1], 16-bit data.
   localparam int ADDR_HI = 23;
   localparam int ADDR_LO = 1;
   localparam int DATA_W  = 16;

   // Legal range of the peripheral read latency, in cycles.
   localparam int READ_LAT_MIN = 1;
   localparam int READ_LAT_MAX = 3;

   // Requester indices as carried by the grant logic and the latched transfer.
   localparam logic GRANT_M0 = 1'b0;
   localparam logic GRANT_M1 = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_WAIT   = 2'd2,
      ST_ACK    = 2'd3
   } arb_state_e;

   // Everything captured from the winning requester in IDLE; the bus access
   // is driven purely from this record so requester inputs may change freely
   // once it is latched.
   typedef struct packed {
      logic                    idx;
      logic                    we;
      logic [ADDR_HI:ADDR_LO]  addr;
      logic [DATA_W-1:0]       wdata;
   } xfer_t;

   // Number of extra WAIT cycles minus one, i.e. the value loaded into the
   // wait counter on leaving ACCESS. Only meaningful for latencies >= 2.
   function automatic logic [1:0] wait_init(input int read_lat);
      return (read_lat > 2) ? 2'(read_lat - 2) : 2'd0;
   endfunction

endpackage

// File: rtl/arb_grant_select.sv
// Combinational winner selection between the two requesters.
// Ports: req0/req1 - pending requests; last_grant - index granted last time;
//        grant_idx - index of the requester that wins this arbitration.
// Build option PERIPH_ARB_ROUND_ROBIN_EN: defined = alternate on contention,
// undefined = fixed priority with m0 always winning (last_grant ignored).
module arb_grant_select
   import periph_bus_pkg::*;
(
   input  logic req0,
   input  logic req1,
   input  logic last_grant,
   output logic grant_idx
);

`ifdef PERIPH_ARB_ROUND_ROBIN_EN
   // On contention hand the bus to whoever did not have it last; a lone
   // requester always wins.
   always_comb begin
      grant_idx = GRANT_M0;
      if (req0 && req1) begin
         grant_idx = (last_grant == GRANT_M0) ? GRANT_M1 : GRANT_M0;
      end else if (req1) begin
         grant_idx = GRANT_M1;
      end
   end
`else
   // Fixed priority: the pointer input exists only to keep one port list for
   // both builds.
   logic last_grant_unused;
   assign last_grant_unused = last_grant;

   always_comb begin
      grant_idx = GRANT_M0;
      if (!req0 && req1) begin
         grant_idx = GRANT_M1;
      end
   end
`endif

endmodule

// File: rtl/periph_bus_arbiter.sv
// Two-requester arbiter in front of a single 16-bit peripheral bus.
// Ports: clk, reset (async, active-high); m0_*/m1_* request/we/addr/wdata in,
//        ack out; rdata shared captured read data; bus_* peripheral side
//        (address, wdata, rdata, read/write strobes).
// Build option PERIPH_ARB_ROUND_ROBIN_EN selects round-robin arbitration with
// a last-grant pointer; without it m0 has fixed priority and no pointer exists.
//
// Transfer sequence: IDLE latches the winner, ACCESS drives the bus for one
// cycle, WAIT covers READ_LAT-1 cycles on reads, ACK pulses the winner's ack.
// Write ack arrives two cycles after the request is sampled, read ack
// 1+READ_LAT cycles after.
module periph_bus_arbiter
   import periph_bus_pkg::*;
#(
   parameter int READ_LAT = 1
)
(
   input  logic                    clk,
   input  logic                    reset,

   input  logic                    m0_req,
   input  logic                    m0_we,
   input  logic [ADDR_HI:ADDR_LO]  m0_addr,
   input  logic [DATA_W-1:0]       m0_wdata,
   output logic                    m0_ack,

   input  logic                    m1_req,
   input  logic                    m1_we,
   input  logic [ADDR_HI:ADDR_LO]  m1_addr,
   input  logic [DATA_W-1:0]       m1_wdata,
   output logic                    m1_ack,

   output logic [DATA_W-1:0]       rdata,

   output logic [ADDR_HI:ADDR_LO]  bus_address,
   output logic [DATA_W-1:0]       bus_wdata,
   input  logic [DATA_W-1:0]       bus_rdata,
   output logic                    bus_read_enable,
   output logic                    bus_write_enable
);

   // Out-of-range latencies are pulled into the supported window so the
   // wait counter never needs more than two bits.
   localparam int LAT = (READ_LAT < READ_LAT_MIN) ? READ_LAT_MIN :
                        (READ_LAT > READ_LAT_MAX) ? READ_LAT_MAX : READ_LAT;
   localparam logic [1:0] WAIT_INIT = wait_init(LAT);

   arb_state_e        state_q, state_d;
   xfer_t             xfer_q, xfer_d;
   logic [1:0]        wait_cnt_q, wait_cnt_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;

   logic              any_req;
   logic              grant_idx;
   logic              last_grant;

   assign any_req = m0_req | m1_req;

   arb_grant_select u_grant (
      .req0       (m0_req),
      .req1       (m1_req),
      .last_grant (last_grant),
      .grant_idx  (grant_idx)
   );

`ifdef PERIPH_ARB_ROUND_ROBIN_EN
   // Last-grant pointer: resets to m1 so that m0 wins the first contention,
   // then follows every grant taken in IDLE.
   logic last_q, last_d;

   always_comb begin
      last_d = last_q;
      if ((state_q == ST_IDLE) && any_req) begin
         last_d = grant_idx;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         last_q <= GRANT_M1;
      end else begin
         last_q <= last_d;
      end
   end

   assign last_grant = last_q;
`else
   assign last_grant = GRANT_M1;
`endif

   // Next-state and output decode. Bus outputs and acks are pure decodes of
   // the registered state, so an asynchronous reset clears them at once.
   always_comb begin
      state_d          = state_q;
      xfer_d           = xfer_q;
      wait_cnt_d       = wait_cnt_q;
      rdata_d          = rdata_q;
      bus_address      = '0;
      bus_wdata        = '0;
      bus_read_enable  = 1'b0;
      bus_write_enable = 1'b0;
      m0_ack           = 1'b0;
      m1_ack           = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (any_req) begin
               xfer_d.idx   = grant_idx;
               xfer_d.we    = (grant_idx == GRANT_M1) ? m1_we    : m0_we;
               xfer_d.addr  = (grant_idx == GRANT_M1) ? m1_addr  : m0_addr;
               xfer_d.wdata = (grant_idx == GRANT_M1) ? m1_wdata : m0_wdata;
               state_d      = ST_ACCESS;
            end
         end

         ST_ACCESS: begin
            bus_address      = xfer_q.addr;
            bus_wdata        = xfer_q.wdata;
            bus_write_enable = xfer_q.we;
            bus_read_enable  = ~xfer_q.we;
            if (xfer_q.we) begin
               state_d = ST_ACK;
            end else if (LAT == READ_LAT_MIN) begin
               // Single-cycle peripheral: data is taken on the edge leaving ACCESS.
               rdata_d = bus_rdata;
               state_d = ST_ACK;
            end else begin
               wait_cnt_d = WAIT_INIT;
               state_d    = ST_WAIT;
            end
         end

         ST_WAIT: begin
            if (wait_cnt_q == 2'd0) begin
               rdata_d = bus_rdata;
               state_d = ST_ACK;
            end else begin
               wait_cnt_d = wait_cnt_q - 2'd1;
            end
         end

         ST_ACK: begin
            m0_ack  = (xfer_q.idx == GRANT_M0);
            m1_ack  = (xfer_q.idx == GRANT_M1);
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         xfer_q     <= '0;
         wait_cnt_q <= '0;
         rdata_q    <= '0;
      end else begin
         state_q    <= state_d;
         xfer_q     <= xfer_d;
         wait_cnt_q <= wait_cnt_d;
         rdata_q    <= rdata_d;
      end
   end

   assign rdata = rdata_q;

endmodule

// File: tb/tb_periph_bus_arbiter.sv
`timescale 1ns/1ps
module tb_periph_bus_arbiter;
   import periph_bus_pkg::*;

   localparam int RL = 2;

   typedef struct packed {
      logic        we;
      logic [23:1] addr;
      logic [15:0] wdata;
   } tx_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        m0_req, m0_we, m1_req, m1_we;
   logic [23:1] m0_addr, m1_addr;
   logic [15:0] m0_wdata, m1_wdata;
   logic        m0_ack, m1_ack;
   logic [15:0] rdata;
   logic [23:1] bus_address;
   logic [15:0] bus_wdata;
   logic [15:0] bus_rdata;
   logic        bus_read_enable, bus_write_enable;

   periph_bus_arbiter #(.READ_LAT(RL)) dut (
      .clk              (clk),
      .reset            (reset),
      .m0_req           (m0_req),
      .m0_we            (m0_we),
      .m0_addr          (m0_addr),
      .m0_wdata         (m0_wdata),
      .m0_ack           (m0_ack),
      .m1_req           (m1_req),
      .m1_we            (m1_we),
      .m1_addr          (m1_addr),
      .m1_wdata         (m1_wdata),
      .m1_ack           (m1_ack),
      .rdata            (rdata),
      .bus_address      (bus_address),
      .bus_wdata        (bus_wdata),
      .bus_rdata        (bus_rdata),
      .bus_read_enable  (bus_read_enable),
      .bus_write_enable (bus_write_enable)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;
   int edge_n = 0;

   // Peripheral: read data is a fixed function of the last address strobed
   // for read, offset by a per-test salt.
   logic [23:1] rd_addr = '0;
   logic [15:0] salt = '0;
   assign bus_rdata = rd_hash(rd_addr) ^ salt;

   // Reference model: one transfer at a time, latency by arithmetic.
   logic        last_m = 1'b1;
   logic        tx_vld = 1'b0;
   int          tx_who = 0;
   tx_t         tx_m = '0;
   int          tx_sample = 0;
   int          tx_lat = 0;
   int          free_edge = 0;
   logic [15:0] rdata_m = '0;

   // Requester drivers and observations.
   tx_t         q0[$];
   tx_t         q1[$];
   logic [1:0]  infl = '0;
   logic [1:0]  ackseen = '0;
   int          dly[2] = '{0, 0};
   int          gap_max = 0;
   int          ack_cnt[2] = '{0, 0};
   int          ord[$];
   int          wr_cnt = 0, rd_cnt = 0, strobe_edge = 0, ack_edge = 0;

   function automatic logic [15:0] rd_hash(input logic [23:1] a);
      return a[16:1] ^ {a[23:17], 9'h0A5};
   endfunction

   function automatic tx_t rand_tx();
      tx_t t;
      t.we    = 1'($urandom);
      t.addr  = 23'($urandom);
      t.wdata = 16'($urandom);
      return t;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic drive(input int n, input logic req, input tx_t t);
      if (n == 0) begin
         m0_req = req; m0_we = t.we; m0_addr = t.addr; m0_wdata = t.wdata;
      end else begin
         m1_req = req; m1_we = t.we; m1_addr = t.addr; m1_wdata = t.wdata;
      end
   endtask

   function automatic int qsize(input int n);
      return (n == 0) ? q0.size() : q1.size();
   endfunction

   task automatic present(input int n);
      if (dly[n] > 0) begin
         dly[n]--;
         drive(n, 1'b0, '0);
      end else if (qsize(n) > 0) begin
         drive(n, 1'b1, (n == 0) ? q0[0] : q1[0]);
      end else begin
         drive(n, 1'b0, '0);
      end
   endtask

   task automatic kick();
      for (int n = 0; n < 2; n++) if (!infl[n]) present(n);
   endtask

   task automatic step();
      logic sr0, sr1;
      tx_t  st0, st1;
      int   w;
      logic acc, ackx;
      sr0 = m0_req; sr1 = m1_req;
      st0 = '{m0_we, m0_addr, m0_wdata};
      st1 = '{m1_we, m1_addr, m1_wdata};
      @(posedge clk);
      edge_n++;
      w = -1;
      if (edge_n >= free_edge && (sr0 || sr1)) begin
`ifdef PERIPH_ARB_ROUND_ROBIN_EN
         if (sr0 && sr1) w = last_m ? 0 : 1;
         else            w = sr0 ? 0 : 1;
`else
         w = sr0 ? 0 : 1;
`endif
         last_m    = (w == 1);
         tx_vld    = 1'b1;
         tx_who    = w;
         tx_m      = (w == 0) ? st0 : st1;
         tx_sample = edge_n;
         tx_lat    = tx_m.we ? 2 : 1 + RL;
         free_edge = edge_n + tx_lat + 1;
      end
      #1;
      for (int n = 0; n < 2; n++) begin
         if (ackseen[n]) begin
            ackseen[n] = 1'b0;
            infl[n]    = 1'b0;
            if (n == 0) void'(q0.pop_front()); else void'(q1.pop_front());
            dly[n] = int'($urandom_range(gap_max, 0));
         end
      end
      if (w >= 0) infl[w] = 1'b1;
      // The latched requester scrambles its own inputs until its ack.
      for (int n = 0; n < 2; n++) begin
         if (infl[n]) drive(n, 1'($urandom), rand_tx());
         else         present(n);
      end
      @(negedge clk);
      acc  = tx_vld && (tx_sample == edge_n);
      ackx = tx_vld && (edge_n == tx_sample + tx_lat - 1);
      if (ackx && !tx_m.we) rdata_m = rd_hash(tx_m.addr) ^ salt;
      chk("rd_en",  32'(bus_read_enable),  32'(acc && !tx_m.we));
      chk("wr_en",  32'(bus_write_enable), 32'(acc && tx_m.we));
      chk("addr",   32'(bus_address),      32'(acc ? tx_m.addr : 23'd0));
      chk("wdata",  32'(bus_wdata),        32'(acc ? tx_m.wdata : 16'd0));
      chk("m0_ack", 32'(m0_ack),           32'(ackx && tx_who == 0));
      chk("m1_ack", 32'(m1_ack),           32'(ackx && tx_who == 1));
      chk("rdata",  32'(rdata),            32'(rdata_m));
      chk("one_strobe", 32'(bus_read_enable & bus_write_enable), 32'd0);
      if (bus_read_enable) begin rd_addr = bus_address; rd_cnt++; end
      if (bus_write_enable) wr_cnt++;
      if (bus_read_enable || bus_write_enable) strobe_edge = edge_n;
      if (m0_ack) begin ackseen[0] = 1'b1; ack_cnt[0]++; ord.push_back(0); ack_edge = edge_n; end
      if (m1_ack) begin ackseen[1] = 1'b1; ack_cnt[1]++; ord.push_back(1); ack_edge = edge_n; end
   endtask

   task automatic drain(input int budget);
      int n = 0;
      while ((q0.size() > 0 || q1.size() > 0 || edge_n < free_edge) && n < budget) begin
         step();
         n++;
      end
      chk("drain_pending", 32'(q0.size() + q1.size()), 32'd0);
   endtask

   initial begin
      int w0, r0, a0, n;
      logic [15:0] keep;
      logic [23:1] ra;
      tx_t t;

      reset = 1'b1;
      drive(0, 1'b0, '0);
      drive(1, 1'b0, '0);
      #2;
      chk("rst_rd_en", 32'(bus_read_enable), 32'd0);
      chk("rst_wr_en", 32'(bus_write_enable), 32'd0);
      chk("rst_acks",  32'({m0_ack, m1_ack}), 32'd0);
      chk("rst_rdata", 32'(rdata), 32'd0);
      chk("rst_addr",  32'(bus_address), 32'd0);
      chk("rst_wdata", 32'(bus_wdata), 32'd0);
      @(posedge clk); @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);

      // m0 write of BEEF to 091A2B.
      w0 = wr_cnt;
      q0.push_back('{1'b1, 23'h091A2B, 16'hBEEF});
      kick();
      drain(40);
      chk("wr_strobe_cycles", 32'(wr_cnt - w0), 32'd1);
      chk("wr_ack_latency",   32'(ack_edge - strobe_edge + 1), 32'd2);

      // m1 read returning 1234.
      r0 = rd_cnt;
      ra = 23'h2A0F00;
      salt = 16'h1234 ^ rd_hash(ra);
      q1.push_back('{1'b0, ra, 16'h0});
      kick();
      drain(40);
      chk("rd_strobe_cycles", 32'(rd_cnt - r0), 32'd1);
      chk("rd_ack_latency",   32'(ack_edge - strobe_edge + 1), 32'(1 + RL));
      chk("rd_value",         32'(rdata), 32'h1234);

      // Four back-to-back transfers from each requester, both always pending.
      ord.delete();
      for (int i = 0; i < 4; i++) begin
         q0.push_back(rand_tx());
         q1.push_back(rand_tx());
      end
      kick();
      drain(200);
      chk("order_len", 32'(ord.size()), 32'd8);
      for (int i = 0; i < 8 && i < ord.size(); i++) begin
`ifdef PERIPH_ARB_ROUND_ROBIN_EN
         chk("grant_order", 32'(ord[i]), 32'(i % 2));
`else
         chk("grant_order", 32'(ord[i]), 32'(i < 4 ? 0 : 1));
`endif
      end

      // A write leaves the captured read data alone.
      keep = rdata_m;
      q1.push_back('{1'b1, 23'h000123, 16'hA5A5});
      kick();
      drain(40);
      chk("write_keeps_rdata", 32'(rdata), 32'(keep));

      // Reset while a read sits in WAIT, then retry.
      q0.push_back('{1'b0, 23'h00ABCD, 16'h0});
      kick();
      n = 0;
      while (!(tx_vld && tx_sample == edge_n && tx_who == 0) && n < 20) begin
         step();
         n++;
      end
      chk("wait_rd_sampled", 32'(n < 20), 32'd1);
      step();
      #1 reset = 1'b1;
      #1;
      chk("midrst_rd_en", 32'(bus_read_enable), 32'd0);
      chk("midrst_wr_en", 32'(bus_write_enable), 32'd0);
      chk("midrst_acks",  32'({m0_ack, m1_ack}), 32'd0);
      chk("midrst_rdata", 32'(rdata), 32'd0);
      chk("midrst_addr",  32'(bus_address), 32'd0);
      tx_vld = 1'b0; free_edge = 0; last_m = 1'b1; rdata_m = '0;
      infl = '0; ackseen = '0;
      kick();
      @(posedge clk);
      edge_n++;
      #1 reset = 1'b0;
      a0 = ack_cnt[0];
      drain(60);
      chk("retry_acks", 32'(ack_cnt[0] - a0), 32'd1);

      // Random mix with idle gaps.
      gap_max = 3;
      salt = 16'($urandom);
      for (int i = 0; i < 40; i++) begin
         t = rand_tx();
         if ($urandom_range(1, 0) == 0) q0.push_back(t); else q1.push_back(t);
      end
      kick();
      drain(3000);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog expired: observed no finish, required finish");
      $fatal(1, "watchdog");
   end

endmodule
